// File: rtl/filter_sample_feeder.sv
// filter_sample_feeder: buffers ADC samples in a FIFO and hands them one at a time to the notch filter.
// Optional build macro FEEDER_STATS_EN adds saturating processed/dropped sample counters.
module filter_sample_feeder #(
    parameter int DATA_SIZE   = 24,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_SIZE-1:0]               s_data,
    input  logic                               s_valid,
    output logic [DATA_SIZE-1:0]               f_data,
    output logic                               f_trig,
    input  logic                               f_done,
    input  logic                               ovr_clr,
    output logic                               overrun,
    output logic                               ack_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]                        stat_proc,
    output logic [15:0]                        stat_drop
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_ACK, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_SIZE-1:0]   f_data_q, f_data_d;
    logic [7:0]             tmo_cnt_q, tmo_cnt_d;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   ack_err_q, ack_err_d;
    logic [DATA_SIZE-1:0]   mem_q [FIFO_DEPTH];
    logic                   empty, full, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push  = s_valid && (!full || pop);

    // FSM next state; a non-zero hold counter in IDLE marks the one recovery cycle after HOLD,
    // giving the filter a gap so samples are issued every HOLD_CYCLES+4 cycles.
    always_comb begin
        state_d    = state_q;
        f_data_d   = f_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        ack_err_d  = ack_err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_cnt_q != 8'd0) begin
                    hold_cnt_d = 8'd0;
                end else if (!empty) begin
                    pop      = 1'b1;
                    f_data_d = mem_q[rd_ptr_q[AW-1:0]];
                    state_d  = TRIG;
                end
            end
            TRIG: begin
                tmo_cnt_d = 8'd0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (f_done) begin
                    hold_cnt_d = 8'd0;
                    state_d    = HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_cnt_q + 8'd1 == 8'(ACK_TIMEOUT)) begin
                        ack_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                state_d    = (hold_cnt_q == 8'(HOLD_CYCLES - 1)) ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer advance and sticky overrun, where a drop wins over a clear.
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_INC : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_INC : rd_ptr_q;
        overrun_d = (s_valid && !push) ? 1'b1 : ovr_clr ? 1'b0 : overrun_q;
    end

    // Control and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            f_data_q   <= '0;
            tmo_cnt_q  <= '0;
            hold_cnt_q <= '0;
            overrun_q  <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            f_data_q   <= f_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            overrun_q  <= overrun_d;
            ack_err_q  <= ack_err_d;
        end
    end

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end

    assign f_data  = f_data_q;
    assign f_trig  = (state_q == TRIG);
    assign overrun = overrun_q;
    assign ack_err = ack_err_q;
    assign level   = LW'(wr_ptr_q - rd_ptr_q);

`ifdef FEEDER_STATS_EN
    logic [15:0] stat_proc_q, stat_proc_d, stat_drop_q, stat_drop_d;

    // Saturating counts of acknowledged and discarded samples.
    always_comb begin
        stat_proc_d = (state_q == WAIT_ACK && f_done && stat_proc_q != 16'hFFFF) ? stat_proc_q + 16'd1 : stat_proc_q;
        stat_drop_d = (s_valid && !push && stat_drop_q != 16'hFFFF) ? stat_drop_q + 16'd1 : stat_drop_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_proc_q <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_proc_q <= stat_proc_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_proc = stat_proc_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_filter_sample_feeder.sv
// tb_filter_sample_feeder: directed vectors and corner sequences for filter_sample_feeder.
module tb_filter_sample_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        f_done = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [23:0] f_data;
    logic        f_trig, overrun, ack_err;
    logic [3:0]  level;
`ifdef FEEDER_STATS_EN
    logic [15:0] stat_proc, stat_drop;
`endif

    filter_sample_feeder dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .f_data(f_data), .f_trig(f_trig), .f_done(f_done), .ovr_clr(ovr_clr),
        .overrun(overrun), .ack_err(ack_err), .level(level)
`ifdef FEEDER_STATS_EN
        , .stat_proc(stat_proc), .stat_drop(stat_drop)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [23:0] sd, input logic fd, input logic oc);
        s_valid = sv;
        s_data  = sd;
        f_done  = fd;
        ovr_clr = oc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 24'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        sv;
        logic [23:0] sd;
        logic        fd;
        logic        oc;
        logic        trig;
        logic [23:0] data;
        logic [3:0]  lvl;
        logic        ovr;
        logic        aerr;
    } vec_t;

    vec_t tbl[12];
    int   ntrig, peak, c;
    logic last_trig;

    initial begin
        // Row k: inputs for cycle k, and outputs expected during cycle k.
        tbl[0]  = '{1'b1, 24'h123456, 1'b0, 1'b0, 1'b0, 24'h000000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 4'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 24'hFEDCBA, 1'b0, 1'b0, 1'b0, 24'h123456, 4'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h123456, 4'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'hFEDCBA, 4'd0, 1'b0, 1'b0};

        // Asynchronous reset: outputs must clear before any clock edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_trig", 32'(f_trig), 32'd0);
        chk("rst_data", 32'(f_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
`ifdef FEEDER_STATS_EN
        chk("rst_stat_proc", 32'(stat_proc), 32'd0);
        chk("rst_stat_drop", 32'(stat_drop), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Single sample, including an ignored f_done during HOLD and a second negative sample.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_trig", i), 32'(f_trig), 32'(tbl[i].trig));
            chk($sformatf("vec%0d_data", i), 32'(f_data), 32'(tbl[i].data));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
            chk($sformatf("vec%0d_ack_err", i), 32'(ack_err), 32'(tbl[i].aerr));
            drive(tbl[i].sv, tbl[i].sd, tbl[i].fd, tbl[i].oc);
        end

        // Burst of 8 with prompt acknowledge: in-order delivery every 8 cycles.
        do_reset();
        ntrig = 0;
        peak = 0;
        last_trig = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (f_trig) begin
                chk("burst_trig_cycle", 32'(k), 32'(2 + 8 * ntrig));
                chk("burst_data", 32'(f_data), 32'(24'hA00000 + 24'(ntrig)));
                ntrig++;
            end
            if (int'(level) > peak) peak = int'(level);
            drive(k < 8, 24'hA00000 + 24'(k), last_trig, 1'b0);
            last_trig = f_trig;
        end
        drive(1'b0, 24'h0, 1'b0, 1'b0);
        chk("burst_count", 32'(ntrig), 32'd8);
        chk("burst_peak_level", 32'(peak), 32'd7);
        chk("burst_overrun", 32'(overrun), 32'd0);

        // Overflow, timeout, full+pop acceptance, ovr_clr behaviour, set-beats-clear.
        do_reset();
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            c = k;
            if (c == 9) begin
                chk("ovf_level_full", 32'(level), 32'd8);
                chk("ovf_overrun_pre", 32'(overrun), 32'd0);
            end
            if (c == 10) begin
                chk("ovf_overrun_set", 32'(overrun), 32'd1);
                chk("ovf_level_held", 32'(level), 32'd8);
            end
            if (c == 13) begin
                chk("ovf_overrun_clr", 32'(overrun), 32'd0);
                chk("ovf_ack_err_pre", 32'(ack_err), 32'd0);
            end
            if (c == 17) chk("tmo_ack_err_early", 32'(ack_err), 32'd0);
            if (c == 18) begin
                chk("tmo_ack_err_rise", 32'(ack_err), 32'd1);
                chk("tmo_level", 32'(level), 32'd8);
            end
            if (c == 19) begin
                chk("tmo_next_trig", 32'(f_trig), 32'd1);
                chk("tmo_next_data", 32'(f_data), 32'h00B00001);
                chk("fullpop_level", 32'(level), 32'd8);
                chk("fullpop_overrun", 32'(overrun), 32'd0);
            end
            if (c == 21) begin
                chk("clr_keeps_ack_err", 32'(ack_err), 32'd1);
                chk("clr_overrun", 32'(overrun), 32'd0);
            end
            if (c == 22) chk("set_beats_clr", 32'(overrun), 32'd1);
            if (c == 36) begin
                chk("tmo2_trig", 32'(f_trig), 32'd1);
                chk("tmo2_data", 32'(f_data), 32'h00B00002);
                chk("tmo2_level", 32'(level), 32'd7);
            end
            drive((c < 10) || c == 18 || c == 21,
                  (c == 18) ? 24'hC0FFEE : (c == 21) ? 24'hDEAD00 : 24'hB00000 + 24'(c),
                  1'b0, c == 12 || c == 20 || c == 21);
        end

        // Asynchronous reset in HOLD with 3 samples queued.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(k < 4, 24'hD00000 + 24'(k), k == 3, 1'b0);
        end
        @(negedge clk);
        chk("hold_level", 32'(level), 32'd3);
        chk("hold_data", 32'(f_data), 32'h00D00000);
        drive(1'b0, 24'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("arst_trig", 32'(f_trig), 32'd0);
        chk("arst_data", 32'(f_data), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_ack_err", 32'(ack_err), 32'd0);
`ifdef FEEDER_STATS_EN
        chk("arst_stat_proc", 32'(stat_proc), 32'd0);
        chk("arst_stat_drop", 32'(stat_drop), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        ntrig = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (f_trig) ntrig++;
        end
        chk("arst_no_trig", 32'(ntrig), 32'd0);
        chk("arst_level_after", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
